fx3_slfifo_resp: RTL
====================

Name: fx3_slfifo_resp

Overview:
- Synthesizable model of the FX3 side of the GPIF II slave-FIFO interface.
- Drives FLAGA..D and DQ; samples SLCSn/SLOEn/SLRDn/SLWRn/PKTENDn/SLADDR/DQ from the FPGA-side FX3 controller.
- Sources words for endpoint 0 (the controller's DP0 path) from a local push port. Sinks words written to endpoints 1..3 (DP1..DP3 paths) into a local ready/valid stream.
- Used for board loopback and bench closure of the USB interface without a real FX3.

Parameters:
- GpifWidth, 32, DQ bus width.
- SrcDepth, 16, source FIFO depth in words; power of 2.
- SnkDepth, 16, sink FIFO depth in words; power of 2.
- RdLat, 2, cycles from sampled SLRDn low to data on DQ_o; range 1..4.
- FlagLat, 2, flag pipeline delay after FIFO state change; range 1..4.
- Wm, 4, watermark for the partial flags FLAGC/FLAGD.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- SLCSn_i  in  1  chip select, active low.
- SLOEn_i  in  1  output enable, active low.
- SLRDn_i  in  1  read strobe, active low.
- SLWRn_i  in  1  write strobe, active low.
- PKTENDn_i  in  1  packet end, active low.
- SLADDR_i  in  2  endpoint address.
- DQ_i  in  GpifWidth  data from the FPGA.
- DQ_o  out  GpifWidth  data to the FPGA.
- FLAGA_o  out  1  low = endpoint 0 empty.
- FLAGB_o  out  1  low = sink full.
- FLAGC_o  out  1  low = source count <= Wm.
- FLAGD_o  out  1  low = sink free space <= Wm.
- src_dt_i  in  GpifWidth  local data pushed toward endpoint 0.
- src_wr_i  in  1  push strobe.
- src_full_o  out  1  source FIFO full.
- snk_dt_o  out  GpifWidth  received word.
- snk_addr_o  out  2  endpoint the word was written to.
- snk_last_o  out  1  word closed a packet (PKTENDn low).
- snk_vld_o  out  1  sink word valid.
- snk_rdy_i  in  1  sink consumer ready.
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset values (asynchronous on rst_i high):
  - DQ_o=0, FLAGA_o=0, FLAGB_o=1, FLAGC_o=0, FLAGD_o=1.
  - src_full_o=0, snk_vld_o=0, err_o=0.
  - Both FIFOs empty; all pipelines cleared.
- Reset asserted mid-transfer: in-flight read pipeline data and unread sink words are discarded.
- Access cycle: SLCSn_i=0. Signals are sampled each rising edge; SLCSn_i=1 ignores all strobes.
- Read, with SLADDR_i=0, SLRDn_i=0, source not empty:
  - Pop one word.
  - The word appears on DQ_o exactly RdLat cycles after the sampling edge.
  - Back-to-back reads give one word per cycle.
- Read on empty source: no pop. The pipeline slot carries 0; the error event fires.
- DQ_o while SLOEn_i=1: forced to 0. Pipeline contents are unaffected.
- DQ_o with no read in flight: holds the last driven word.
- Write, with SLADDR_i in 1..3, SLWRn_i=0, sink not full:
  - Push {SLADDR_i, DQ_i, last=~PKTENDn_i}.
  - If the sink is full, the word is dropped and the error event fires.
- Zero-length packet (PKTENDn_i=0 with SLWRn_i=1, SLADDR_i!=0): push {addr, 0, last=1}.
- Strobe/address mismatch (SLWRn_i=0 at addr 0, or SLRDn_i=0 at addr !=0): ignored; error event.
- SLRDn_i and SLWRn_i both low: both ignored; error event.
- Source push: on src_wr_i when not full. Push on full is dropped.
- Source pop and push in the same cycle: count unchanged.
- src_full_o: combinational from the count.
- Sink output: first-word-fall-through.
  - snk_vld_o = sink not empty.
  - Pop on snk_vld_o & snk_rdy_i.
  - Push and pop in the same cycle are allowed when not full.
- Flags: computed from post-update FIFO counts and delayed through FlagLat registers.
  - The FPGA may therefore overrun by up to FlagLat words.
  - Overrun words are dropped per the rules above.
- Counters: log2(Depth)+1 bits; pointers wrap modulo Depth.

Optional Feature:
- Macro FX3_RESP_CHECK_EN.
- Defined: err_o is set by any error event and stays high until reset.
  - A per-cause 4-bit sticky register {rd_empty, wr_full, addr_mismatch, rd_wr_both} is also kept.
  - The register is visible by hierarchy to the bench.
- Not defined: error logic is not built; err_o is tied 0. Data-path behaviour is identical.

Decomposition:
- Package fx3_resp_pkg:
  - Endpoint address constants EP_SRC=0, EP_SNK_MIN=1.
  - Typedef snk_word_t = struct {addr[1:0], last, data[GpifWidth-1:0]}.
  - Error-cause bit index constants.
- One sub-module, fx3_resp_sfifo: single-clock synchronous FIFO with count output; instantiated twice (source and sink).

Test Plan:
- Push 0xA0000001..0xA0000004 on src; with SLCSn=0 and SLOEn=0, hold SLRDn=0 at addr 0 for 4 cycles -> DQ_o shows the four words in order, first one RdLat=2 cycles after the first strobe; FLAGA_o goes 0 FlagLat cycles after the last pop.
- Write 0x11,0x22,0x33 to addr 2, with PKTENDn=0 on 0x33 -> sink delivers addr=2 for all three, last=0,0,1; snk_rdy held low holds snk_vld high with data stable.
- Fill the sink with 16 words, then write 2 more -> FLAGB_o=0 FlagLat cycles after the 16th; the extra words are dropped; err_o=1 with wr_full set (macro on).
- SLRDn=0 at addr 0 with the source empty -> DQ_o=0 after RdLat cycles, no pop; err_o=1, rd_empty set; with the macro off, err_o stays 0.
- SLOEn=1 during a read burst -> DQ_o=0; returning SLOEn to 0 shows the current pipeline word.
- Assert rst_i mid-burst (async, between edges) -> all outputs immediately return to their reset values; FIFOs are empty after release.

Source files
------------

// File: rtl/fx3_resp_pkg.sv
// Shared constants and types for the FX3 slave-FIFO responder model.
// Endpoint map, sink word layout and error-cause bit positions.
package fx3_resp_pkg;

    localparam logic [1:0] EP_SRC     = 2'd0;
    localparam logic [1:0] EP_SNK_MIN = 2'd1;

    localparam int GPIF_WIDTH = 32;

    // Sink word layout; the top packs {addr, last, data} in this order.
    typedef struct packed {
        logic [1:0]            addr;
        logic                  last;
        logic [GPIF_WIDTH-1:0] data;
    } snk_word_t;

    localparam int ERR_W             = 4;
    localparam int ERR_RD_EMPTY      = 3;
    localparam int ERR_WR_FULL       = 2;
    localparam int ERR_ADDR_MISMATCH = 1;
    localparam int ERR_RD_WR_BOTH    = 0;

endpackage

// File: rtl/fx3_resp_sfifo.sv
// Single-clock synchronous FIFO with occupancy count and first-word-fall-through read data.
// Writes on full and reads on empty are ignored.
module fx3_resp_sfifo #(
    parameter int W     = 32,
    parameter int Depth = 16,
    localparam int AW   = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_dt,
    input  logic          rd_en,
    output logic [W-1:0]  rd_dt,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(Depth);

    logic [W-1:0]  mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign rd_dt = mem[rd_ptr];

    // Storage is not reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fx3_slfifo_resp.sv
// FX3 side of the GPIF II slave-FIFO interface: EP0 sourced from a local push port, EP1..3 sunk to a stream.
// Optional sticky protocol-error tracking is built when FX3_RESP_CHECK_EN is defined.
module fx3_slfifo_resp
    import fx3_resp_pkg::*;
#(
    parameter int GpifWidth = 32,
    parameter int SrcDepth  = 16,
    parameter int SnkDepth  = 16,
    parameter int RdLat     = 2,
    parameter int FlagLat   = 2,
    parameter int Wm        = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 SLCSn_i,
    input  logic                 SLOEn_i,
    input  logic                 SLRDn_i,
    input  logic                 SLWRn_i,
    input  logic                 PKTENDn_i,
    input  logic [1:0]           SLADDR_i,
    input  logic [GpifWidth-1:0] DQ_i,
    output logic [GpifWidth-1:0] DQ_o,
    output logic                 FLAGA_o,
    output logic                 FLAGB_o,
    output logic                 FLAGC_o,
    output logic                 FLAGD_o,
    input  logic [GpifWidth-1:0] src_dt_i,
    input  logic                 src_wr_i,
    output logic                 src_full_o,
    output logic [GpifWidth-1:0] snk_dt_o,
    output logic [1:0]           snk_addr_o,
    output logic                 snk_last_o,
    output logic                 snk_vld_o,
    input  logic                 snk_rdy_i,
    output logic                 err_o
);

    localparam int SrcCW = $clog2(SrcDepth) + 1;
    localparam int SnkCW = $clog2(SnkDepth) + 1;
    localparam int SnkW  = GpifWidth + 3;

    localparam logic [SrcCW-1:0] SRC_WM       = SrcCW'(Wm);
    localparam logic [SnkCW-1:0] SNK_WM       = SnkCW'(Wm);
    localparam logic [SnkCW-1:0] SNK_FULL_CNT = SnkCW'(SnkDepth);
    // Flag order is {A, B, C, D}; reset value reflects both FIFOs empty.
    localparam logic [3:0] FLAG_RST = {1'b0, 1'b1, 1'b0, (SNK_FULL_CNT > SNK_WM)};

    logic                 cs;
    logic                 rd_stb;
    logic                 wr_stb;
    logic                 pe_stb;
    logic                 addr_src;
    logic                 addr_snk;
    logic                 rd_req;
    logic                 wr_req;
    logic                 zlp_req;
    logic                 snk_push;
    logic [GpifWidth-1:0] snk_data;
    logic [SnkW-1:0]      snk_wdt;
    logic [SnkW-1:0]      snk_rdt;

    logic [GpifWidth-1:0] src_rdt;
    logic [SrcCW-1:0]     src_cnt;
    logic [SnkCW-1:0]     snk_cnt;
    logic                 src_full;
    logic                 src_empty;
    logic                 snk_full;
    logic                 snk_empty;

    assign cs       = ~SLCSn_i;
    assign rd_stb   = cs & ~SLRDn_i;
    assign wr_stb   = cs & ~SLWRn_i;
    assign pe_stb   = cs & ~PKTENDn_i;
    assign addr_src = (SLADDR_i == EP_SRC);
    assign addr_snk = (SLADDR_i >= EP_SNK_MIN);

    // Simultaneous read and write strobes cancel each other entirely.
    assign rd_req   = rd_stb & ~wr_stb & addr_src;
    assign wr_req   = wr_stb & ~rd_stb & addr_snk;
    assign zlp_req  = pe_stb & ~wr_stb & ~rd_stb & addr_snk;
    assign snk_push = wr_req | zlp_req;
    assign snk_data = zlp_req ? '0 : DQ_i;
    assign snk_wdt  = {SLADDR_i, pe_stb, snk_data};

    fx3_resp_sfifo #(
        .W     (GpifWidth),
        .Depth (SrcDepth)
    ) u_src_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (src_wr_i),
        .wr_dt (src_dt_i),
        .rd_en (rd_req),
        .rd_dt (src_rdt),
        .count (src_cnt),
        .full  (src_full),
        .empty (src_empty)
    );

    fx3_resp_sfifo #(
        .W     (SnkW),
        .Depth (SnkDepth)
    ) u_snk_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (snk_push),
        .wr_dt (snk_wdt),
        .rd_en (snk_rdy_i),
        .rd_dt (snk_rdt),
        .count (snk_cnt),
        .full  (snk_full),
        .empty (snk_empty)
    );

    assign src_full_o = src_full;

    // Sink stream: a word moves on every cycle with snk_vld_o & snk_rdy_i high; snk_vld_o never depends on snk_rdy_i.
    assign snk_vld_o  = ~snk_empty;
    assign snk_dt_o   = snk_rdt[GpifWidth-1:0];
    assign snk_last_o = snk_rdt[GpifWidth];
    assign snk_addr_o = snk_rdt[GpifWidth+2 -: 2];

    // Read pipeline: stage 0 captures at the sampling edge, dq_hold loads RdLat edges later.
    logic [RdLat-1:0]     rp_vld;
    logic [GpifWidth-1:0] rp_dt [RdLat];
    logic [GpifWidth-1:0] dq_hold;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rp_vld  <= '0;
            dq_hold <= '0;
            for (int i = 0; i < RdLat; i++) begin
                rp_dt[i] <= '0;
            end
        end else begin
            rp_vld[0] <= rd_req;
            rp_dt[0]  <= src_empty ? '0 : src_rdt;
            for (int i = 1; i < RdLat; i++) begin
                rp_vld[i] <= rp_vld[i-1];
                rp_dt[i]  <= rp_dt[i-1];
            end
            if (rp_vld[RdLat-1]) begin
                dq_hold <= rp_dt[RdLat-1];
            end
        end
    end

    assign DQ_o = SLOEn_i ? '0 : dq_hold;

    logic [3:0] flag_raw;
    logic [3:0] flag_pipe [FlagLat];

    assign flag_raw = {~src_empty,
                       ~snk_full,
                       (src_cnt > SRC_WM),
                       ((SNK_FULL_CNT - snk_cnt) > SNK_WM)};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FlagLat; i++) begin
                flag_pipe[i] <= FLAG_RST;
            end
        end else begin
            flag_pipe[0] <= flag_raw;
            for (int i = 1; i < FlagLat; i++) begin
                flag_pipe[i] <= flag_pipe[i-1];
            end
        end
    end

    assign FLAGA_o = flag_pipe[FlagLat-1][3];
    assign FLAGB_o = flag_pipe[FlagLat-1][2];
    assign FLAGC_o = flag_pipe[FlagLat-1][1];
    assign FLAGD_o = flag_pipe[FlagLat-1][0];

`ifdef FX3_RESP_CHECK_EN
    logic [ERR_W-1:0] err_ev;
    logic [ERR_W-1:0] err_cause;

    always_comb begin
        err_ev                    = '0;
        err_ev[ERR_RD_EMPTY]      = rd_req & src_empty;
        err_ev[ERR_WR_FULL]       = snk_push & snk_full;
        err_ev[ERR_ADDR_MISMATCH] = (wr_stb & ~rd_stb & addr_src) | (rd_stb & ~wr_stb & ~addr_src);
        err_ev[ERR_RD_WR_BOTH]    = rd_stb & wr_stb;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cause <= '0;
        end else begin
            err_cause <= err_cause | err_ev;
        end
    end

    assign err_o = |err_cause;
`else
    assign err_o = 1'b0;
`endif

endmodule
